// File: rtl/branch_predict_resolve_unit.sv
// EX-stage conditional branch resolver with a BHT of saturating counters for IF-stage
// prediction, mispredict detection and saturating branch/mispredict performance counters.
module branch_predict_resolve_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned PERF_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           pred_pc,
    output logic                  pred_taken,
    input  logic                  branch,
    input  logic [DATA_WIDTH-1:0] input0,
    input  logic [DATA_WIDTH-1:0] input1,
    input  logic [5:0]            Branch_Code,
    input  logic [31:0]           res_pc,
    input  logic                  res_pred_taken,
    input  logic                  ex_stall,
    output logic                  branch_taken,
    output logic                  mispredict,
    output logic [PERF_WIDTH-1:0] branch_count,
    output logic [PERF_WIDTH-1:0] mispredict_count
);

    localparam int unsigned IDX = $clog2(BHT_ENTRIES);

    localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_MAX >> 1;
    localparam logic [PERF_WIDTH-1:0] PERF_MAX = '1;

    localparam logic [5:0] BC_BEQ  = 6'h03;
    localparam logic [5:0] BC_BNE  = 6'h04;
    localparam logic [5:0] BC_BLEZ = 6'h07;
    localparam logic [5:0] BC_BGTZ = 6'h0F;
    localparam logic [5:0] BC_BGEZ = 6'h11;
    localparam logic [5:0] BC_BLTZ = 6'h13;

    logic [CTR_BITS-1:0]   r_bht [BHT_ENTRIES];
    logic [PERF_WIDTH-1:0] r_branch_count;
    logic [PERF_WIDTH-1:0] r_mispredict_count;

    logic [IDX-1:0] w_pred_idx;
    logic [IDX-1:0] w_res_idx;
    logic           w_neg;
    logic           w_zero;
    logic           w_known;
    logic           w_cond;
    logic           w_update;

    assign w_pred_idx = pred_pc[IDX+1:2];
    assign w_res_idx  = res_pc[IDX+1:2];

    // Signed compares against zero reduce to the sign bit and a zero test.
    assign w_neg  = input0[DATA_WIDTH-1];
    assign w_zero = (input0 == '0);

    always_comb begin
        w_known = 1'b1;
        w_cond  = 1'b0;
        case (Branch_Code)
            BC_BEQ:  w_cond = (input0 == input1);
            BC_BNE:  w_cond = (input0 != input1);
            BC_BLEZ: w_cond = w_neg | w_zero;
            BC_BGTZ: w_cond = ~w_neg & ~w_zero;
            BC_BGEZ: w_cond = ~w_neg;
            BC_BLTZ: w_cond = w_neg;
            default: w_known = 1'b0;
        endcase
    end

    assign branch_taken     = branch & w_known & w_cond;
    // Unknown codes still flag a mispredict so a predicted-taken one gets redirected.
    assign mispredict       = branch & (branch_taken ^ res_pred_taken);
    assign pred_taken       = r_bht[w_pred_idx][CTR_BITS-1];
    assign w_update         = branch & w_known & ~ex_stall;
    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= CTR_INIT;
            end
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else if (w_update) begin
            if (branch_taken) begin
                if (r_bht[w_res_idx] != CTR_MAX) begin
                    r_bht[w_res_idx] <= r_bht[w_res_idx] + 1'b1;
                end
            end else if (r_bht[w_res_idx] != '0) begin
                r_bht[w_res_idx] <= r_bht[w_res_idx] - 1'b1;
            end
            if (r_branch_count != PERF_MAX) begin
                r_branch_count <= r_branch_count + 1'b1;
            end
            if (mispredict && (r_mispredict_count != PERF_MAX)) begin
                r_mispredict_count <= r_mispredict_count + 1'b1;
            end
        end
    end

endmodule
